// File: rtl/cache_controller.sv
// Direct-mapped, 4-column write-back data cache controller. Sequences the tag and
// data RAMs, serves the CPU load/store port and moves whole lines over the burst port.
module cache_controller #(
    parameter int LINE_IX_BITWIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [31:0]                 cpu_address,
    input  logic [31:0]                 cpu_wdata,
    output logic [31:0]                 cpu_rdata,
    output logic                        cpu_ready,
    output logic [LINE_IX_BITWIDTH-1:0] cache_line_ix,
    output logic                        cache_tag_we,
    output logic [31:0]                 cache_tag_wdata,
    input  logic [31:0]                 cache_tag_rdata,
    output logic [3:0]                  cache_data_we,
    output logic [31:0]                 cache_data_wdata,
    input  logic [127:0]                cache_data_rdata,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [31:0]                 mem_address,
    output logic [31:0]                 mem_wdata,
    input  logic                        mem_wready,
    input  logic [31:0]                 mem_rdata,
    input  logic                        mem_rvalid
);
    localparam int LINE_COUNT   = 2**LINE_IX_BITWIDTH;
    localparam int TAG_BITWIDTH = 32 - LINE_IX_BITWIDTH - 4;
    localparam int PAD_BITWIDTH = 32 - TAG_BITWIDTH - 2;

    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, WRITEBACK, FILL} state_t;

    state_t                      state_q;
    logic [LINE_IX_BITWIDTH-1:0] init_cnt_q;
    logic [LINE_IX_BITWIDTH-1:0] line_q;
    logic [TAG_BITWIDTH-1:0]     tag_q;
    logic [TAG_BITWIDTH-1:0]     wb_tag_q;
    logic [127:0]                wb_buf_q;
    logic [31:0]                 wdata_q;
    logic [1:0]                  col_q;
    logic [1:0]                  beat_q;
    logic                        we_q;
    logic                        mem_req_q;

    logic [TAG_BITWIDTH-1:0] stored_tag;
    logic                    stored_valid, stored_dirty, hit;
    logic                    unused_bits;

    assign stored_tag   = cache_tag_rdata[TAG_BITWIDTH-1:0];
    assign stored_dirty = cache_tag_rdata[TAG_BITWIDTH];
    assign stored_valid = cache_tag_rdata[TAG_BITWIDTH+1];
    assign hit          = stored_valid && (stored_tag == tag_q);
    assign unused_bits  = ^{cpu_address[1:0], cache_tag_rdata[31:TAG_BITWIDTH+2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            line_q     <= '0;
            tag_q      <= '0;
            wb_tag_q   <= '0;
            wb_buf_q   <= '0;
            wdata_q    <= '0;
            col_q      <= '0;
            beat_q     <= '0;
            we_q       <= 1'b0;
            mem_req_q  <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == LINE_IX_BITWIDTH'(LINE_COUNT - 1)) state_q <= IDLE;
                end
                IDLE: if (cpu_req) begin
                    tag_q   <= cpu_address[31 -: TAG_BITWIDTH];
                    line_q  <= cpu_address[LINE_IX_BITWIDTH+3:4];
                    col_q   <= cpu_address[3:2];
                    we_q    <= cpu_we;
                    wdata_q <= cpu_wdata;
                    state_q <= LOOKUP;
                end
                LOOKUP: begin
                    beat_q <= '0;
                    if (hit) begin
                        state_q <= IDLE;
                    end else if (stored_valid && stored_dirty) begin
                        // Snapshot the victim so the burst never re-reads the RAMs.
                        wb_tag_q  <= stored_tag;
                        wb_buf_q  <= cache_data_rdata;
                        mem_req_q <= 1'b1;
                        state_q   <= WRITEBACK;
                    end else begin
                        mem_req_q <= 1'b1;
                        state_q   <= FILL;
                    end
                end
                WRITEBACK: if (mem_wready) begin
                    beat_q <= beat_q + 1'b1;
                    if (beat_q == 2'd3) begin
                        mem_req_q <= 1'b0;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    // Entered from WRITEBACK with mem_req low: that cycle is the burst gap.
                    if (!mem_req_q) begin
                        mem_req_q <= 1'b1;
                    end else if (mem_rvalid) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == 2'd3) begin
                            mem_req_q <= 1'b0;
                            state_q   <= LOOKUP;
                        end
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    always_comb begin
        cpu_ready        = 1'b0;
        cpu_rdata        = '0;
        cache_tag_we     = 1'b0;
        cache_tag_wdata  = '0;
        cache_data_we    = '0;
        cache_data_wdata = '0;
        case (state_q)
            INIT:    cache_line_ix = init_cnt_q;
            IDLE:    cache_line_ix = cpu_address[LINE_IX_BITWIDTH+3:4];
            default: cache_line_ix = line_q;
        endcase
        case (state_q)
            INIT: cache_tag_we = rst_n;
            LOOKUP: if (hit) begin
                cpu_ready = 1'b1;
                if (we_q) begin
                    cache_data_we[col_q] = 1'b1;
                    cache_data_wdata     = wdata_q;
                    cache_tag_we         = 1'b1;
                    cache_tag_wdata      = {{PAD_BITWIDTH{1'b0}}, 1'b1, 1'b1, tag_q};
                end else begin
                    cpu_rdata = cache_data_rdata[{col_q, 5'b0} +: 32];
                end
            end
            FILL: if (mem_req_q && mem_rvalid) begin
                cache_data_we[beat_q] = 1'b1;
                cache_data_wdata      = mem_rdata;
                if (beat_q == 2'd3) begin
                    cache_tag_we    = 1'b1;
                    cache_tag_wdata = {{PAD_BITWIDTH{1'b0}}, 1'b1, 1'b0, tag_q};
                end
            end
            default: ;
        endcase
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = (state_q == WRITEBACK);
    assign mem_address = (state_q == WRITEBACK) ? {wb_tag_q, line_q, 4'b0} :
                         (state_q == FILL)      ? {tag_q, line_q, 4'b0}    : 32'b0;
    assign mem_wdata   = (state_q == WRITEBACK) ? wb_buf_q[{beat_q, 5'b0} +: 32] : 32'b0;

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller with 16 lines: RAM and burst-memory models, a load-data
// scoreboard, a vector table and directed reset / writeback / mid-burst-reset sequences.
module tb_cache_controller;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req, cpu_we;
    logic [31:0]  cpu_address, cpu_wdata, cpu_rdata;
    logic         cpu_ready;
    logic [L-1:0] cache_line_ix;
    logic         cache_tag_we;
    logic [31:0]  cache_tag_wdata;
    logic [31:0]  cache_tag_rdata = '0;
    logic [3:0]   cache_data_we;
    logic [31:0]  cache_data_wdata;
    logic [127:0] cache_data_rdata = '0;
    logic         mem_req, mem_we, mem_wready, mem_rvalid;
    logic [31:0]  mem_address, mem_wdata, mem_rdata;

    cache_controller #(.LINE_IX_BITWIDTH(L)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .cache_line_ix(cache_line_ix), .cache_tag_we(cache_tag_we),
        .cache_tag_wdata(cache_tag_wdata), .cache_tag_rdata(cache_tag_rdata),
        .cache_data_we(cache_data_we), .cache_data_wdata(cache_data_wdata),
        .cache_data_rdata(cache_data_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_wready(mem_wready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid));

    always #5 clk = ~clk;

    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp; bit mem; } vec_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } beat_t;

    int checks = 0, errors = 0;
    int cyc = 0, req_cyc = 0, rv_seen = 0, wb_seen = 0, last_rv_cyc = 0, wb_cnt = 0, rv_cnt = 0;
    bit prev_wb = 0;
    logic [31:0] fill_addr_last = '0;
    logic [31:0] sb[$];
    beat_t       wb_exp[$];
    logic [31:0] ext_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] tag_ram [16];
    logic [31:0] data_ram [16][4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Backing-memory contents: line 0x100 holds 0xA0..0xA3, other lines distinct values.
    function automatic logic [31:0] def_word(input logic [31:0] a);
        return 32'hA0 + {30'b0, a[3:2]} + (((a & ~32'hF) - 32'h100) << 4);
    endfunction
    function automatic logic [31:0] ext_rd(input logic [31:0] a);
        return ext_mem.exists(a & ~32'h3) ? ext_mem[a & ~32'h3] : def_word(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a & ~32'h3) ? ref_mem[a & ~32'h3] : def_word(a);
    endfunction

    // Single-port RAMs, one-cycle read, write data forwarded to the read port.
    always @(posedge clk) begin
        if (cache_tag_we) tag_ram[cache_line_ix] <= cache_tag_wdata;
        cache_tag_rdata <= cache_tag_we ? cache_tag_wdata : tag_ram[cache_line_ix];
        for (int c = 0; c < 4; c++) begin
            if (cache_data_we[c]) data_ram[cache_line_ix][c] <= cache_data_wdata;
            cache_data_rdata[c*32 +: 32] <= cache_data_we[c] ? cache_data_wdata : data_ram[cache_line_ix][c];
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Burst memory responder with random stalls.
    initial begin
        mem_rvalid = 1'b0; mem_rdata = '0; mem_wready = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0; mem_wready = 1'b0;
            if (!mem_req) rv_cnt = 0;
            else if (mem_we) mem_wready = ($urandom_range(0, 2) != 0);
            else if (rv_cnt < 4 && $urandom_range(0, 2) != 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = ext_rd(mem_address + 32'(4 * rv_cnt));
                rv_cnt++;
            end
        end
    end

    // Monitor: accepts writeback beats, tracks fills, checks load data against the scoreboard.
    initial forever begin
        logic [31:0] a;
        beat_t e;
        @(negedge clk);
        if (mem_req) req_cyc++;
        if (mem_req && mem_we && mem_wready) begin
            a = mem_address + 32'(4 * wb_cnt);
            ext_mem[a] = mem_wdata;
            wb_seen++;
            if (wb_exp.size() != 0) begin
                e = wb_exp.pop_front();
                chk("wb_addr", a, e.addr);
                chk("wb_data", mem_wdata, e.data);
            end
            wb_cnt++;
        end
        if (!mem_req) wb_cnt = 0;
        if (mem_req && !mem_we && mem_rvalid) begin
            rv_seen++;
            last_rv_cyc = cyc;
            fill_addr_last = mem_address;
            chk("fill_align", {28'b0, mem_address[3:0]}, 32'h0);
        end
        if (prev_wb && !(mem_req && mem_we)) chk("wb_fill_gap", {31'b0, mem_req}, 32'h0);
        prev_wb = mem_req && mem_we;
        if (cache_data_we != 4'b0) chk("data_we_onehot", $countones(cache_data_we), 32'd1);
        if (cpu_ready && !cpu_we) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_load_ready rdata=%h expected=none", cpu_rdata);
            end else chk("load_rdata", cpu_rdata, sb.pop_front());
        end
    end

    task automatic wait_ready(output int lat, output int rcyc);
        bit done = 0;
        lat = 0; rcyc = 0;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
            if (cpu_ready) begin done = 1; rcyc = cyc; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL ready_timeout addr=%h actual=no_ready expected=ready", cpu_address);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic cpu_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, output int lat, output int memc);
        int s = req_cyc;
        int rc;
        if (we) ref_mem[addr & ~32'h3] = wdata;
        else sb.push_back(exp);
        cpu_we = we; cpu_address = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        wait_ready(lat, rc);
        memc = req_cyc - s;
    endtask

    vec_t vt[12];
    int lat, memc, rc, k, n;

    task automatic run_vec(input int i);
        cpu_op(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp, lat, memc);
        chk($sformatf("vec%0d_mem", i), {31'b0, memc != 0}, {31'b0, vt[i].mem});
        if (!vt[i].mem) chk($sformatf("vec%0d_hit_lat", i), lat, 32'd2);
    endtask

    initial begin
        vt[0]  = '{0, 32'h0000_0108, 0, 32'hA2, 0};
        vt[1]  = '{1, 32'h0000_010C, 32'hDEADBEEF, 0, 0};
        vt[2]  = '{0, 32'h0000_010C, 0, 32'hDEADBEEF, 0};
        vt[3]  = '{0, 32'h0000_1104, 0, def_word(32'h1104), 0};
        vt[4]  = '{1, 32'h0000_2230, 32'h1111_2222, 0, 1};
        vt[5]  = '{0, 32'h0000_2230, 0, 32'h1111_2222, 0};
        vt[6]  = '{0, 32'h0000_3234, 0, def_word(32'h3234), 1};
        vt[7]  = '{0, 32'h0000_2230, 0, 32'h1111_2222, 1};
        vt[8]  = '{0, 32'h0000_0FF0, 0, def_word(32'h0FF0), 1};
        vt[9]  = '{0, 32'h0000_0FFC, 0, def_word(32'h0FFC), 0};
        vt[10] = '{1, 32'h0000_0FF3, 32'h55, 0, 0};
        vt[11] = '{0, 32'h0000_0FF0, 0, 32'h55, 0};

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {cpu_ready, mem_req, mem_we, cache_tag_we, cache_data_we, cache_line_ix},
            32'h0);
        chk("rst_mem_addr", mem_address, 32'h0);

        // Request held through INIT must be ignored until IDLE, then served as a cold fill.
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.push_back(32'hA1);
        cpu_we = 1'b0; cpu_address = 32'h0000_0104; cpu_req = 1'b1;
        rv_seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("init_tag_we", {31'b0, cache_tag_we}, 32'h1);
            chk("init_line", {28'b0, cache_line_ix}, i);
            chk("init_tag_wdata", cache_tag_wdata, 32'h0);
            chk("init_no_ready", {31'b0, cpu_ready}, 32'h0);
        end
        @(negedge clk);
        chk("idle_cycle16_tag_we", {31'b0, cache_tag_we}, 32'h0);
        wait_ready(lat, rc);
        chk("cold_fill_beats", rv_seen, 32'd4);
        chk("cold_fill_addr", fill_addr_last, 32'h0000_0100);
        chk("cold_ready_after_rv", rc, last_rv_cyc + 1);
        chk("cold_tag_word", tag_ram[0], 32'h0200_0001);

        for (int i = 0; i < 3; i++) run_vec(i);
        chk("store_tag_dirty", tag_ram[0], 32'h0300_0001);
        chk("store_col3", data_ram[0][3], 32'hDEADBEEF);

        // Dirty eviction of line 0 then fill of the new tag.
        wb_exp.push_back('{32'h100, 32'hA0});
        wb_exp.push_back('{32'h104, 32'hA1});
        wb_exp.push_back('{32'h108, 32'hA2});
        wb_exp.push_back('{32'h10C, 32'hDEADBEEF});
        wb_seen = 0; rv_seen = 0;
        cpu_op(0, 32'h0000_1100, 0, def_word(32'h1100), lat, memc);
        chk("evict_wb_beats", wb_seen, 32'd4);
        chk("evict_wb_pending", wb_exp.size(), 32'd0);
        chk("evict_fill_addr", fill_addr_last, 32'h0000_1100);
        chk("evict_fill_beats", rv_seen, 32'd4);

        // Reset during a fill after beat 2.
        rv_seen = 0;
        cpu_we = 1'b0; cpu_address = 32'h0000_2100; cpu_req = 1'b1;
        k = 0;
        while (rv_seen < 3 && k < 400) begin @(negedge clk); #1; k++; end
        chk("midfill_beats", rv_seen, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("midfill_rst_req", {31'b0, mem_req}, 32'h0);
        chk("midfill_rst_we", {cache_data_we, cache_tag_we, cpu_ready}, 32'h0);
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cache_tag_we) n++;
        end
        chk("reinit_tag_writes", n, 32'd16);
        @(posedge clk); #1;
        rv_seen = 0;
        cpu_op(0, 32'h0000_1100, 0, def_word(32'h1100), lat, memc);
        chk("post_reset_refill", rv_seen, 32'd4);

        for (int i = 3; i < 12; i++) run_vec(i);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, d;
            bit w;
            a = {22'b0, 2'($urandom_range(0, 3)), 2'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b0};
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            cpu_op(w, a, d, ref_rd(a), lat, memc);
        end
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
